mux_16: RTL and testbench
=========================

Name: mux_16

Overview:
- 16-to-1 data selector with a registered output, parameterised on data width.
- Used in MCU datapaths wherever one of sixteen equal-width buses is chosen by a 4-bit index, e.g. register/CSR read-back and result selection.
- Output is captured in a flop, so downstream logic sees a clean, glitch-free value one clock after the select.

Parameters:
- DATA_WIDTH, default 32, width in bits of every data input and of out (instantiated at 64 in the MCU).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sel  input  4  index of the input to forward (0..15).
- in0..in15  input  DATA_WIDTH each  data inputs; inK is selected when sel == K.
- out  output  DATA_WIDTH  registered selected data.

Interface (already decided):
- One clock (clk).
- Reset rst is asynchronous and active-high.

Behaviour:
- Combinational stage: next = in[sel].
  - Full case over all 16 sel codes.
  - Any sel containing X/Z drives next to all-zeros; no latch is inferred.
- Register stage:
  - On posedge clk with rst low, out <= next.
  - Latency: exactly 1 cycle from sel or data change to out.
- Reset:
  - While rst is high, out = {DATA_WIDTH{1'b0}}, forced immediately without waiting for clk.
  - Reset asserted mid-operation clears out at once.
  - On the first posedge after rst deasserts, out loads in[sel].
- Data changes on the selected input propagate with the same 1-cycle latency.
- Changes on unselected inputs have no effect on out.
- sel may change every cycle; each cycle's out reflects the sel/data sampled at the previous edge.
- No handshake, no enable, no other state; throughput is 1 selection per cycle.
- Width rule: out is a bit-exact copy of the selected input; no extension, truncation or arithmetic.

Decomposition:
- Shared package: the constant for the number of inputs (16) and the select width (4). DATA_WIDTH remains a module parameter.
- One natural sub-module, mux_16_comb: the purely combinational 16:1 selector. The top module adds the async-reset output register around it.
- No further hierarchy.

Test Plan:
- Reset: hold rst=1 with sel=5 and in5=0x5 while toggling clk -> out=0. Assert rst asynchronously between edges -> out goes to 0 immediately, without waiting for an edge.
- Sweep: DATA_WIDTH=64, inK=K for K=0..9 and in10..in15=0x10..0x15; step sel 0..15, one per cycle -> out on the cycle after each step equals 0x0..0x9 then 0x10..0x15, in order.
- Latency: at one edge change sel from 3 to 12 -> out stays 0x3 until the next posedge, then becomes 0x12.
- Isolation: sel=7 steady; change in6 and in8 to 0xFFFF_FFFF_FFFF_FFFF -> out remains 0x7. Change in7 to 0xDEAD_BEEF_0000_0001 -> out follows one cycle later.
- Width: all inputs are distinct full-width patterns (alternating 0xAAAA... and 0x5555..., MSB set); select each in turn -> out matches bit-exactly, including bit 63.
- Release: deassert rst with sel=15 and in15=0x15 -> the first posedge after release gives out=0x15.

Source files
------------

// File: rtl/mux_16_pkg.sv
// Shared constants for the 16:1 registered selector.
package mux_16_pkg;

    localparam int NUM_INPUTS = 16;
    localparam int SEL_WIDTH  = 4;

    typedef logic [SEL_WIDTH-1:0] sel_t;

endpackage

// File: rtl/mux_16_if.sv
// Bus bundle for mux_16: select index, sixteen data inputs and the registered result.
interface mux_16_if #(
    parameter int DATA_WIDTH = 32
);
    import mux_16_pkg::*;

    sel_t                  sel;
    logic [DATA_WIDTH-1:0] in0,  in1,  in2,  in3;
    logic [DATA_WIDTH-1:0] in4,  in5,  in6,  in7;
    logic [DATA_WIDTH-1:0] in8,  in9,  in10, in11;
    logic [DATA_WIDTH-1:0] in12, in13, in14, in15;
    logic [DATA_WIDTH-1:0] out;

    modport master (
        output sel,
        output in0, in1, in2, in3, in4, in5, in6, in7,
        output in8, in9, in10, in11, in12, in13, in14, in15,
        input  out
    );

    modport slave (
        input  sel,
        input  in0, in1, in2, in3, in4, in5, in6, in7,
        input  in8, in9, in10, in11, in12, in13, in14, in15,
        output out
    );

endinterface

// File: rtl/mux_16_comb.sv
// Purely combinational 16:1 selector; an unknown select yields all-zeros.
module mux_16_comb
    import mux_16_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  sel_t                  sel,
    input  logic [DATA_WIDTH-1:0] bank [NUM_INPUTS],
    output logic [DATA_WIDTH-1:0] sel_data
);

    always_comb begin
        sel_data = '0;
        case (sel)
            4'd0:    sel_data = bank[0];
            4'd1:    sel_data = bank[1];
            4'd2:    sel_data = bank[2];
            4'd3:    sel_data = bank[3];
            4'd4:    sel_data = bank[4];
            4'd5:    sel_data = bank[5];
            4'd6:    sel_data = bank[6];
            4'd7:    sel_data = bank[7];
            4'd8:    sel_data = bank[8];
            4'd9:    sel_data = bank[9];
            4'd10:   sel_data = bank[10];
            4'd11:   sel_data = bank[11];
            4'd12:   sel_data = bank[12];
            4'd13:   sel_data = bank[13];
            4'd14:   sel_data = bank[14];
            4'd15:   sel_data = bank[15];
            // Only reachable when sel carries X/Z.
            default: sel_data = '0;
        endcase
    end

endmodule

// File: rtl/mux_16.sv
// 16:1 data selector with an async-reset output register (one cycle latency).
module mux_16
    import mux_16_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    mux_16_if.slave  bus
);

    logic [DATA_WIDTH-1:0] bank [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] out_q;

    assign bank[0]  = bus.in0;
    assign bank[1]  = bus.in1;
    assign bank[2]  = bus.in2;
    assign bank[3]  = bus.in3;
    assign bank[4]  = bus.in4;
    assign bank[5]  = bus.in5;
    assign bank[6]  = bus.in6;
    assign bank[7]  = bus.in7;
    assign bank[8]  = bus.in8;
    assign bank[9]  = bus.in9;
    assign bank[10] = bus.in10;
    assign bank[11] = bus.in11;
    assign bank[12] = bus.in12;
    assign bank[13] = bus.in13;
    assign bank[14] = bus.in14;
    assign bank[15] = bus.in15;

    mux_16_comb #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_comb (
        .sel      (bus.sel),
        .bank     (bank),
        .sel_data (sel_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= sel_data;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_mux_16.sv
// Directed plus random bench for mux_16 at 64-bit width.
module tb_mux_16;

    localparam int DW = 64;

    logic          clk;
    logic          rst;
    logic [3:0]    sel_v;
    logic [DW-1:0] m [16];
    logic [DW-1:0] exp_out;
    int            checks;
    int            errors;

    mux_16_if #(.DATA_WIDTH(DW)) bus ();

    mux_16 #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        bus.sel  = sel_v;
        bus.in0  = m[0];  bus.in1  = m[1];  bus.in2  = m[2];  bus.in3  = m[3];
        bus.in4  = m[4];  bus.in5  = m[5];  bus.in6  = m[6];  bus.in7  = m[7];
        bus.in8  = m[8];  bus.in9  = m[9];  bus.in10 = m[10]; bus.in11 = m[11];
        bus.in12 = m[12]; bus.in13 = m[13]; bus.in14 = m[14]; bus.in15 = m[15];
    endtask

    // Reference: a clocked copy of in[sel], or zero while reset is held.
    task automatic tick();
        drive();
        @(posedge clk);
        exp_out = rst ? '0 : m[sel_v];
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] expv);
        checks++;
        assert (bus.out === expv)
        else begin
            errors++;
            $error("FAIL %s: out=%h expected=%h", tag, bus.out, expv);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_out = '0;
        rst = 1'b1;
        sel_v = 4'd5;
        for (int k = 0; k < 16; k++) m[k] = '0;
        m[5] = 64'h5;
        drive();
        #1;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", 64'h0);
        end

        rst = 1'b0;
        tick();
        check("post_reset_load", 64'h5);

        #2 rst = 1'b1;
        #1 check("async_reset", 64'h0);
        tick();
        check("reset_edge", exp_out);

        sel_v = 4'd15;
        m[15] = 64'h15;
        drive();
        #2 rst = 1'b0;
        tick();
        check("release", 64'h15);

        for (int k = 0; k < 16; k++) m[k] = (k < 10) ? 64'(k) : 64'(16 + k - 10);
        for (int k = 0; k < 16; k++) begin
            sel_v = 4'(k);
            tick();
            check("sweep", (k < 10) ? 64'(k) : 64'(16 + k - 10));
        end

        sel_v = 4'd3;
        tick();
        check("latency_pre", 64'h3);
        sel_v = 4'd12;
        drive();
        #2 check("latency_hold", 64'h3);
        tick();
        check("latency_post", 64'h12);

        sel_v = 4'd7;
        tick();
        check("iso_base", 64'h7);
        m[6] = '1;
        m[8] = '1;
        tick();
        check("iso_neighbours", 64'h7);
        m[7] = 64'hDEAD_BEEF_0000_0001;
        drive();
        #2 check("iso_before_edge", 64'h7);
        tick();
        check("iso_follow", 64'hDEAD_BEEF_0000_0001);

        for (int k = 0; k < 16; k++)
            m[k] = ((k % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'hD555_5555_5555_5555)
                   ^ (64'(k) << 8);
        for (int k = 15; k >= 0; k--) begin
            sel_v = 4'(k);
            tick();
            check("width", ((k % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'hD555_5555_5555_5555)
                           ^ (64'(k) << 8));
        end

        for (int i = 0; i < 300; i++) begin
            sel_v = 4'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++) m[k] = {$urandom(), $urandom()};
            if ($urandom_range(0, 19) == 0) begin
                drive();
                #2 rst = 1'b1;
                #1 check("rand_async_reset", 64'h0);
                rst = 1'b0;
            end
            tick();
            check("random", exp_out);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, out=%h expected=%h", bus.out, exp_out);
        $fatal(1, "timeout");
    end

endmodule
